counter_lag_checker: RTL

COUNTER_LAG_CHECKER -- requirements
Module: counter_lag_checker

---
 rtl/counter_check_pkg.sv | 22 ++
 rtl/counter_lag_checker_delay_line.sv | 36 +++
 rtl/counter_lag_checker.sv | 98 +++++++++
 3 files changed

// File: rtl/counter_check_pkg.sv
// Shared definitions for the lagged counter checker.
//   state_t       : checker FSM state encoding (IDLE/WARMUP/CHECK)
//   WARM_W        : width of the warm-up down-counter (covers lag 0..15)
//   warm_load()   : warm-up counter load value for a given lag
package counter_check_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    WARMUP = 2'd1,
    CHECK  = 2'd2
  } state_t;

  localparam int WARM_W = 4;

  // WARMUP exits when the counter reads zero, so it spends load+1 cycles
  // there. A lag of 0 still needs one WARMUP cycle.
  function automatic logic [WARM_W-1:0] warm_load(input int lag);
    if (lag == 0) return '0;
    else          return WARM_W'(lag - 1);
  endfunction

endpackage

// File: rtl/counter_lag_checker_delay_line.sv
// delay_line: DEPTH-stage register pipeline with synchronous active-low clear.
// DEPTH = 0 degenerates to a combinational pass-through.
//   clk  : clock
//   rstn : synchronous active-low clear of every stage
//   din  : input word
//   dout : din delayed by DEPTH cycles
module delay_line #(
  parameter int WIDTH = 64,
  parameter int DEPTH = 2
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout
);

  generate
    if (DEPTH == 0) begin : g_pass
      assign dout = din;
    end else begin : g_line
      logic [WIDTH-1:0] stage [DEPTH];

      always_ff @(posedge clk) begin
        if (!rstn) begin
          for (int i = 0; i < DEPTH; i++) stage[i] <= '0;
        end else begin
          stage[0] <= din;
          for (int i = 1; i < DEPTH; i++) stage[i] <= stage[i-1];
        end
      end

      assign dout = stage[DEPTH-1];
    end
  endgenerate

endmodule

// File: rtl/counter_lag_checker.sv
// counter_lag_checker: compares a pipelined count against a golden count
// delayed by LAG cycles and records miscompares.
//   clk       : clock (posedge)
//   rstn      : synchronous active-low reset
//   start     : one-cycle pulse, arms checking from IDLE
//   ref_cnt   : golden count
//   dut_cnt   : count under check, expected to trail ref_cnt by LAG cycles
//   checking  : high in CHECK
//   mismatch  : one-cycle pulse, one cycle after each miscompared sample
//   err_cnt   : saturating miscompare count
//   fail      : sticky, set on the first miscompare
//   first_exp : expected value at the first miscompare
//   first_got : dut_cnt value at the first miscompare
//
// state  | meaning
// IDLE   | waiting for start
// WARMUP | delay line filling, lasts max(LAG,1) cycles
// CHECK  | comparing every cycle until reset
module counter_lag_checker
  import counter_check_pkg::*;
#(
  parameter int WIDTH = 64,
  parameter int LAG   = 2,
  parameter int ERR_W = 16
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             start,
  input  logic [WIDTH-1:0] ref_cnt,
  input  logic [WIDTH-1:0] dut_cnt,
  output logic             checking,
  output logic             mismatch,
  output logic [ERR_W-1:0] err_cnt,
  output logic             fail,
  output logic [WIDTH-1:0] first_exp,
  output logic [WIDTH-1:0] first_got
);

  localparam logic [WARM_W-1:0] WARM_LOAD = warm_load(LAG);

  state_t            state;
  logic [WARM_W-1:0] warm_cnt;
  logic [WIDTH-1:0]  exp_cnt;
  logic              miscmp;

  // Shifts regardless of state so it is already full when CHECK begins.
  delay_line #(
    .WIDTH (WIDTH),
    .DEPTH (LAG)
  ) u_delay (
    .clk  (clk),
    .rstn (rstn),
    .din  (ref_cnt),
    .dout (exp_cnt)
  );

  assign checking = (state == CHECK);
  assign miscmp   = (state == CHECK) && (exp_cnt != dut_cnt);

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state     <= IDLE;
      warm_cnt  <= '0;
      mismatch  <= 1'b0;
      err_cnt   <= '0;
      fail      <= 1'b0;
      first_exp <= '0;
      first_got <= '0;
    end else begin
      mismatch <= miscmp;

      case (state)
        IDLE: begin
          if (start) begin
            state    <= WARMUP;
            warm_cnt <= WARM_LOAD;
          end
        end
        WARMUP: begin
          if (warm_cnt == '0) state <= CHECK;
          else                warm_cnt <= warm_cnt - 1'b1;
        end
        CHECK:   state <= CHECK;
        default: state <= IDLE;
      endcase

      if (miscmp) begin
        if (err_cnt != '1) err_cnt <= err_cnt + ERR_W'(1);
        if (!fail) begin
          fail      <= 1'b1;
          first_exp <= exp_cnt;
          first_got <= dut_cnt;
        end
      end
    end
  end

endmodule
